// File: rtl/seg_readback.sv
// seg_readback: monitors a multiplexed 7-segment bus and recovers the hex
// value, dp bit and glyph-legality flag shown on each digit.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   STABLE_CYCLES  identical registered samples needed before a capture (2..255)
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   seg          segment bus {dp,a,b,c,d,e,f,g}, active-high
//   dig_sel      one-hot digit enable, active-high
//   hex_out      captured nibble per digit, digit i at [4i+3:4i]
//   dp_out       captured dp bit per digit
//   digit_err    1 = last capture on that digit was not a hex glyph
//   frame_valid  one-cycle pulse once every digit has been captured
module seg_readback #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   sel_q, sel_prev_q;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    fv_q, fv_d;

    logic       same;
    logic       sel_ok;
    logic       capture;
    logic [4:0] glyph;

    // {legal, value}
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = {1'b1, 4'h0};
            7'h30:   r = {1'b1, 4'h1};
            7'h6D:   r = {1'b1, 4'h2};
            7'h79:   r = {1'b1, 4'h3};
            7'h33:   r = {1'b1, 4'h4};
            7'h5B:   r = {1'b1, 4'h5};
            7'h5F:   r = {1'b1, 4'h6};
            7'h70:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h7B:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h1F:   r = {1'b1, 4'hB};
            7'h4E:   r = {1'b1, 4'hC};
            7'h3D:   r = {1'b1, 4'hD};
            7'h4F:   r = {1'b1, 4'hE};
            7'h47:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    // Input stage plus one-cycle-old copy for change detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q      <= '0;
            sel_q      <= '0;
            seg_prev_q <= '0;
            sel_prev_q <= '0;
        end else begin
            seg_q      <= seg;
            sel_q      <= dig_sel;
            seg_prev_q <= seg_q;
            sel_prev_q <= sel_q;
        end
    end

    assign same   = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
    assign sel_ok = is_onehot(sel_q);
    assign glyph  = decode(seg_q[6:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLE: begin
                if (same) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = CAPTURED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (sel_ok) begin
                    cnt_d = 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            CAPTURED: begin
                if (!same) begin
                    state_d = sel_ok ? SETTLE : IDLE;
                    cnt_d   = sel_ok ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The sample that completes the window is the one that captures.
    always_comb begin
        capture = (state_q == SETTLE) && same && (cnt_q == CNT_LAST);
    end

    always_comb begin
        hex_d  = hex_q;
        dp_d   = dp_q;
        err_d  = err_q;
        seen_d = seen_q;
        fv_d   = 1'b0;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q[i]) begin
                    dp_d[i]  = seg_q[7];
                    err_d[i] = ~glyph[4];
                    if (glyph[4]) begin
                        hex_d[4*i +: 4] = glyph[3:0];
                    end
                end
            end
            // Frame completes on the capture that fills the mask.
            if (&(seen_q | sel_q)) begin
                fv_d   = 1'b1;
                seen_d = '0;
            end else begin
                seen_d = seen_q | sel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_q  <= '0;
            dp_q   <= '0;
            err_q  <= '0;
            seen_q <= '0;
            fv_q   <= 1'b0;
        end else begin
            hex_q  <= hex_d;
            dp_q   <= dp_d;
            err_q  <= err_d;
            seen_q <= seen_d;
            fv_q   <= fv_d;
        end
    end

    assign hex_out     = hex_q;
    assign dp_out      = dp_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;

endmodule

// File: doc/seg_readback.md
Name: seg_readback

Overview:
- Observes a multiplexed 7-segment display bus (segment byte plus one-hot digit select) and reconstructs the 4-bit hex value shown on each digit.
- Sits at the display pins as a loopback/self-check monitor for the hex-to-segment decode path.
- Flags patterns outside the hex glyph set.
- Pulses a frame strobe once every digit has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- seg  in  8  segment bus; bit7=dp, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; active-high.
- dig_sel  in  NUM_DIGITS  digit enable; active-high, valid only when one-hot.
- hex_out  out  4*NUM_DIGITS  captured value; digit i occupies bits [4i+3:4i].
- dp_out  out  NUM_DIGITS  captured dp bit per digit.
- digit_err  out  NUM_DIGITS  1 = last capture for that digit was not a legal glyph.
- frame_valid  out  1  one-cycle pulse when all digits have been captured since the last pulse.

Behaviour:
- Reset: rst_n low at a rising edge clears hex_out, dp_out, digit_err, frame_valid, the seen mask and the stable counter, and forces state IDLE. Reset asserted mid-settle discards the partial window with no capture.
- Input stage: seg and dig_sel are registered every edge (1 cycle). All comparisons use registered values.
- Glyph table (seg[6:0] -> value):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
  - 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F
  - Any other pattern, including 00, is illegal.
- State IDLE:
  - Registered dig_sel not one-hot (zero or multiple bits): stay in IDLE, counter=0.
  - Registered dig_sel one-hot: go to SETTLE, counter=1.
- State SETTLE:
  - Registered {seg, dig_sel} equal to the previous registered pair: counter increments.
  - Pair changed and new select one-hot: counter=1, stay in SETTLE.
  - Pair changed and new select not one-hot: go to IDLE.
  - Counter reaches STABLE_CYCLES: capture on that edge and go to CAPTURED.
- State CAPTURED:
  - Holds with no further capture while the pair is unchanged.
  - Pair changes: go to SETTLE (counter=1) or IDLE, using the same rule as above.
- Capture into selected digit i:
  - dp_out[i] = seg[7].
  - Legal glyph: hex_out nibble i = table value, digit_err[i] = 0.
  - Illegal glyph: nibble i holds its previous value, digit_err[i] = 1.
  - seen[i] is set in either case.
- Latency: input stable from sampling edge E0 makes outputs visible after edge E0+STABLE_CYCLES. Exactly one capture per stable window.
- Frame:
  - When a capture makes seen all-ones, frame_valid = 1 for that single cycle and seen clears to 0 on the same edge.
  - A digit captured again before the frame completes is not double-counted.
  - NUM_DIGITS=1: every capture pulses frame_valid.
- Non-selected digits' outputs never change.
- dp-only change: counts as a pattern change and restarts settle.

Test Plan:
- Reset: rst_n=0 for 2 cycles with seg=7F, dig_sel=0001 -> all outputs 0, no capture. Release -> capture occurs only after 4 further stable samples.
- Single capture, STABLE_CYCLES=4: seg=79, dig_sel=0010 held 4 cycles -> hex_out=16'h0030, dp_out=0000, digit_err=0000, frame_valid=0. Holding 20 more cycles -> no further update.
- Glitch: seg=5B held 3 cycles then 33 for 1 cycle then 5B again, dig_sel=0001 -> no capture until 4 consecutive 5B samples. Final nibble0=5 (33 never captured).
- Illegal glyph: nibble2 previously C (4E), then seg=00 stable on dig_sel=0100 -> nibble2 stays C, digit_err=0100. Then seg=CF (dp+E) -> nibble2=E, dp_out[2]=1, digit_err=0000.
- Frame: scan digits 0..3 with 7E/30/6D/47, 6 cycles each -> single frame_valid pulse on digit-3 capture, hex_out=16'hF210. Next scan -> exactly one more pulse.
- Bad select: dig_sel=0011 or 0000 with seg=7F for 10 cycles -> no capture, no seen update, no frame_valid.
